// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order FIFO between decode and the reservation stations.
// Each entry is tagged with an FU class when it is pushed. The head entry is
// offered to the RS array and pops only when that class has a free RS slot.
module dispatch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_rs1_value,
  input  logic [XLEN-1:0]          in_rs2_value,
  input  logic [4:0]               in_dest_reg_idx,
  input  logic [3:0]               rs_free,
  output logic                     out_valid,
  output logic [1:0]               out_fu,
  output logic [31:0]              out_inst,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_rs1_value,
  output logic [XLEN-1:0]          out_rs2_value,
  output logic [4:0]               out_dest_reg_idx,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    FU_ALU   = 2'd0,
    FU_LOAD  = 2'd1,
    FU_STORE = 2'd2,
    FU_FP    = 2'd3
  } fu_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      dest;
    fu_e             fu;
  } entry_t;

  // The class is decided once from the major opcode and stored with the entry.
  function automatic fu_e classify(input logic [6:0] opcode);
    case (opcode)
      7'b0000011: return FU_LOAD;
      7'b0100011: return FU_STORE;
      7'b1000011: return FU_FP;
      default:    return FU_ALU;
    endcase
  endfunction

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  entry_t w_in_entry;
  entry_t w_head;
  logic   w_push;
  logic   w_pop;

  // Assemble the incoming entry and fetch the current head entry.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    w_in_entry      = '0;
    w_in_entry.inst = in_inst;
    w_in_entry.pc   = in_pc;
    w_in_entry.rs1  = in_rs1_value;
    w_in_entry.rs2  = in_rs2_value;
    w_in_entry.dest = in_dest_reg_idx;
    w_in_entry.fu   = classify(in_inst[6:0]);
    w_head          = r_mem[r_head];
  end

  // Acceptance depends only on registered occupancy, never on a same-cycle pop,
  // so rs_free has no path to in_ready.
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && rs_free[w_head.fu];

  // Head payload is forced to zero while empty so stale entries never show.
  assign out_fu           = out_valid ? w_head.fu   : FU_ALU;
  assign out_inst         = out_valid ? w_head.inst : '0;
  assign out_pc           = out_valid ? w_head.pc   : '0;
  assign out_rs1_value    = out_valid ? w_head.rs1  : '0;
  assign out_rs2_value    = out_valid ? w_head.rs2  : '0;
  assign out_dest_reg_idx = out_valid ? w_head.dest : '0;
  assign count            = r_count;

  // Entry storage: zeroed on reset, written at the tail on an accepted push.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the array is cleared because reset must leave every entry at zero; a plain FIFO would skip this.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !flush) begin
      r_mem[r_tail] <= w_in_entry;
    end
  end

  // Pointers and occupancy: reset beats flush, flush beats push/pop.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: a constant vector table, directed
// corner-case sequences and randomized traffic, all compared against a
// queue-based reference model.
module tb_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_rs1_value;
  logic [XLEN-1:0]  in_rs2_value;
  logic [4:0]       in_dest_reg_idx;
  logic [3:0]       rs_free;
  logic             out_valid;
  logic [1:0]       out_fu;
  logic [31:0]      out_inst;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_rs1_value;
  logic [XLEN-1:0]  out_rs2_value;
  logic [4:0]       out_dest_reg_idx;
  logic [3:0]       count;

  dispatch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_inst          (in_inst),
    .in_pc            (in_pc),
    .in_rs1_value     (in_rs1_value),
    .in_rs2_value     (in_rs2_value),
    .in_dest_reg_idx  (in_dest_reg_idx),
    .rs_free          (rs_free),
    .out_valid        (out_valid),
    .out_fu           (out_fu),
    .out_inst         (out_inst),
    .out_pc           (out_pc),
    .out_rs1_value    (out_rs1_value),
    .out_rs2_value    (out_rs2_value),
    .out_dest_reg_idx (out_dest_reg_idx),
    .count            (count)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_FP  = 7'b1000011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  dest;
    logic [3:0]  rs_free;
  } stim_t;

  typedef struct {
    stim_t       s;
    int          exp_count;
    bit          exp_valid;
    int          exp_fu;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  dest;
    int          fu;
  } mentry_t;

  mentry_t mq[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input bit valid, input logic [6:0] op, input logic [31:0] pc,
                               input logic [3:0] rf);
    stim_t s;
    s.rst_n   = 1'b1;
    s.flush   = 1'b0;
    s.valid   = valid;
    s.inst    = {pc[24:0], op};
    s.pc      = pc;
    s.rs1     = pc ^ 32'hA5A5_0000;
    s.rs2     = ~pc;
    s.dest    = pc[6:2];
    s.rs_free = rf;
    return s;
  endfunction

  // Class rule written straight from the opcode table.
  function automatic int fu_of(input logic [31:0] inst);
    if (inst[6:0] == OP_LD) return 1;
    if (inst[6:0] == OP_ST) return 2;
    if (inst[6:0] == OP_FP) return 3;
    return 0;
  endfunction

  // Compare every output against the model's view of the queue.
  task automatic model_check();
    mentry_t e;
    int n;
    n = mq.size();
    e = '{inst: 0, pc: 0, rs1: 0, rs2: 0, dest: 0, fu: 0};
    if (n != 0) e = mq[0];
    check("count",     64'(count),            64'(n));
    check("in_ready",  64'(in_ready),         64'(n < DEPTH));
    check("out_valid", 64'(out_valid),        64'(n != 0));
    check("out_fu",    64'(out_fu),           64'(e.fu));
    check("out_inst",  64'(out_inst),         64'(e.inst));
    check("out_pc",    64'(out_pc),           64'(e.pc));
    check("out_rs1",   64'(out_rs1_value),    64'(e.rs1));
    check("out_rs2",   64'(out_rs2_value),    64'(e.rs2));
    check("out_dest",  64'(out_dest_reg_idx), 64'(e.dest));
  endtask

  task automatic model_update(input stim_t s);
    bit pop;
    bit push;
    mentry_t e;
    if (!s.rst_n || s.flush) begin
      mq.delete();
    end else begin
      pop  = (mq.size() != 0) && s.rs_free[mq[0].fu];
      push = s.valid && (mq.size() < DEPTH);
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.inst = s.inst; e.pc = s.pc; e.rs1 = s.rs1; e.rs2 = s.rs2;
        e.dest = s.dest; e.fu = fu_of(s.inst);
        mq.push_back(e);
      end
    end
  endtask

  // Drive inputs away from the edge, then check against the model.
  task automatic apply(input stim_t s);
    @(negedge clock);
    reset           = s.rst_n;
    flush           = s.flush;
    in_valid        = s.valid;
    in_inst         = s.inst;
    in_pc           = s.pc;
    in_rs1_value    = s.rs1;
    in_rs2_value    = s.rs2;
    in_dest_reg_idx = s.dest;
    rs_free         = s.rs_free;
    #1;
    model_check();
  endtask

  task automatic commit(input stim_t s);
    @(posedge clock);
    model_update(s);
  endtask

  task automatic step(input stim_t s);
    apply(s);
    commit(s);
  endtask

  task automatic empty_queue();
    stim_t s;
    s = mk(1'b0, OP_ALU, 0, 4'h0);
    s.flush = 1'b1;
    step(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[6];
    stim_t s;
    logic [31:0] r;
    logic [6:0]  ops[5];

    // Classification table: expectations are the outputs before each edge.
    tbl[0] = '{s: mk(1, OP_LD,  32'h10, 4'hF), exp_count: 0, exp_valid: 0, exp_fu: 0, exp_pc: 32'h00};
    tbl[1] = '{s: mk(1, OP_ST,  32'h14, 4'hF), exp_count: 1, exp_valid: 1, exp_fu: 1, exp_pc: 32'h10};
    tbl[2] = '{s: mk(1, OP_FP,  32'h18, 4'hF), exp_count: 1, exp_valid: 1, exp_fu: 2, exp_pc: 32'h14};
    tbl[3] = '{s: mk(1, OP_ALU, 32'h1C, 4'hF), exp_count: 1, exp_valid: 1, exp_fu: 3, exp_pc: 32'h18};
    tbl[4] = '{s: mk(0, OP_ALU, 32'h00, 4'hF), exp_count: 1, exp_valid: 1, exp_fu: 0, exp_pc: 32'h1C};
    tbl[5] = '{s: mk(0, OP_ALU, 32'h00, 4'hF), exp_count: 0, exp_valid: 0, exp_fu: 0, exp_pc: 32'h00};

    // Reset: held low with in_valid=1; state is unknown before the first edge.
    s = mk(1, OP_LD, 32'h40, 4'hF);
    s.rst_n = 1'b0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_inst = s.inst; in_pc = s.pc;
    in_rs1_value = s.rs1; in_rs2_value = s.rs2; in_dest_reg_idx = s.dest; rs_free = 4'hF;
    commit(s);
    for (int i = 0; i < 2; i++) begin
      apply(s);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      commit(s);
    end
    s = mk(1, OP_LD, 32'h40, 4'h0);
    step(s);
    apply(mk(0, OP_ALU, 0, 4'h0));
    check("first_push_after_reset", 64'(count), 64'd1);
    check("first_push_pc", 64'(out_pc), 64'h40);
    commit(mk(0, OP_ALU, 0, 4'h0));
    empty_queue();

    // Classification, table-driven.
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i].s);
      check($sformatf("tbl%0d_count", i), 64'(count),     64'(tbl[i].exp_count));
      check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_fu", i),    64'(out_fu),    64'(tbl[i].exp_fu));
      check($sformatf("tbl%0d_pc", i),    64'(out_pc),    64'(tbl[i].exp_pc));
      commit(tbl[i].s);
    end

    // Full and wrap: eight pushes with nothing free, a ninth is refused.
    for (int i = 0; i < DEPTH; i++) step(mk(1, OP_ALU, 32'h100 + 32'(4*i), 4'h0));
    apply(mk(1, OP_ALU, 32'h1FC, 4'h0));
    check("full_count", 64'(count), 64'd8);
    check("full_in_ready", 64'(in_ready), 64'd0);
    commit(mk(1, OP_ALU, 32'h1FC, 4'h0));
    // Drain with three new pushes; the model tracks the wrapped order.
    for (int i = 0; i < 14; i++) begin
      if (i >= 1 && i <= 3) s = mk(1, OP_ST, 32'h120 + 32'(4*(i-1)), 4'hF);
      else                  s = mk(0, OP_ALU, 0, 4'hF);
      apply(s);
      if (i < 8) check($sformatf("drain_pc%0d", i), 64'(out_pc), 64'(32'h100 + 32'(4*i)));
      commit(s);
    end

    // Head blocking: a stalled Load holds back a free-class ALU entry.
    step(mk(1, OP_LD,  32'h200, 4'h1));
    step(mk(1, OP_ALU, 32'h204, 4'h1));
    for (int i = 0; i < 5; i++) begin
      apply(mk(0, OP_ALU, 0, 4'h1));
      check("blocked_pc", 64'(out_pc), 64'h200);
      check("blocked_count", 64'(count), 64'd2);
      commit(mk(0, OP_ALU, 0, 4'h1));
    end
    apply(mk(0, OP_ALU, 0, 4'h3));
    check("unblock_pc0", 64'(out_pc), 64'h200);
    commit(mk(0, OP_ALU, 0, 4'h3));
    apply(mk(0, OP_ALU, 0, 4'h3));
    check("unblock_pc1", 64'(out_pc), 64'h204);
    commit(mk(0, OP_ALU, 0, 4'h3));
    step(mk(0, OP_ALU, 0, 4'h3));

    // Simultaneous push and pop at count 4.
    for (int i = 0; i < 4; i++) step(mk(1, OP_LD, 32'h300 + 32'(4*i), 4'h0));
    for (int i = 0; i < 3; i++) begin
      s = mk(1, OP_FP, 32'h310 + 32'(4*i), 4'hF);
      apply(s);
      check("pushpop_count", 64'(count), 64'd4);
      check("pushpop_pc", 64'(out_pc), 64'(32'h300 + 32'(4*i)));
      commit(s);
    end
    apply(mk(0, OP_ALU, 0, 4'h0));
    check("pushpop_after_count", 64'(count), 64'd4);
    commit(mk(0, OP_ALU, 0, 4'h0));
    empty_queue();

    // Flush at count 5 with a push and a pop in the same cycle.
    for (int i = 0; i < 5; i++) step(mk(1, OP_ALU, 32'h400 + 32'(4*i), 4'h0));
    s = mk(1, OP_ALU, 32'h500, 4'hF);
    s.flush = 1'b1;
    step(s);
    apply(mk(0, OP_ALU, 0, 4'hF));
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    commit(mk(0, OP_ALU, 0, 4'hF));

    // Randomized traffic against the model.
    ops[0] = OP_LD; ops[1] = OP_ST; ops[2] = OP_FP; ops[3] = OP_ALU; ops[4] = 7'h13;
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      s = mk($urandom_range(0, 3) != 0, ops[$urandom_range(0, 4)], $urandom(),
             4'($urandom_range(0, 15)));
      s.inst    = {r[31:7], s.inst[6:0]};
      s.rs1     = $urandom();
      s.flush   = ($urandom_range(0, 39) == 0);
      s.rst_n   = ($urandom_range(0, 99) != 0);
      step(s);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- In-order FIFO between decode and the reservation stations. It buffers decoded instructions and classifies each by opcode into an FU class (ALU/Load/Store/FloatingPoint).
- It presents the head entry to the RS array and pops it only when the RS reports a free slot of that class.
- It decouples decode from RS back-pressure and drains on a branch-mispredict flush.

Parameters:
- DEPTH, 8, number of queue entries; power of two, at least 2.
- XLEN, 32, data width of pc and operand values (matches `XLEN`).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; state clears on a rising edge of clock while reset==0.
- flush  in  1  squash all entries (mispredict).
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  instruction PC.
- in_rs1_value  in  XLEN  operand 1.
- in_rs2_value  in  XLEN  operand 2.
- in_dest_reg_idx  in  5  architectural destination.
- rs_free  in  4  one bit per FU class (bit0 ALU, bit1 Load, bit2 Store, bit3 FP); 1 = RS has a free entry of that class.
- out_valid  out  1  head entry valid.
- out_fu  out  2  head FU class: 0 ALU, 1 Load, 2 Store, 3 FP.
- out_inst, out_pc, out_rs1_value, out_rs2_value, out_dest_reg_idx  out  32/XLEN/XLEN/XLEN/5  head payload.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Classification at push, from in_inst[6:0]:
  - 7'b0000011 -> 1 (Load).
  - 7'b0100011 -> 2 (Store).
  - 7'b1000011 -> 3 (FP).
  - Any other opcode -> 0 (ALU).
  - The class is stored with the entry, not recomputed at the head.
- Storage: circular buffer with head and tail pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0. count tracks occupancy 0..DEPTH.
- in_ready = (count != DEPTH). It is purely registered-state based and does not anticipate a same-cycle pop.
- push = in_valid && in_ready. The entry is written at the tail on the edge; tail increments.
- out_valid = (count != 0). out_* are driven combinationally from the head entry. out_* are don't-care when out_valid==0, but the bench expects zeros after reset.
- pop = out_valid && rs_free[out_fu]. The head advances on the edge. The RS latches out_* in the same cycle pop is high.
- Strict in-order dispatch: a blocked head, e.g. a Load with rs_free[1]==0, stalls every younger entry even if its class is free.
- Latency: a pushed entry is visible at the head no earlier than the cycle after the push edge. There is no write-through bypass.
- Simultaneous push and pop: both occur and count is unchanged.
  - At count==DEPTH, no push is possible because in_ready==0, even if a pop occurs.
  - At count==0, no pop is possible; a push is accepted.
- flush==1 at an edge: head, tail and count go to 0. Any same-cycle push and pop are discarded. flush has priority over push/pop.
- reset==0 at an edge: same as flush, and the storage array is zeroed. reset has priority over flush.
- Reset/flush outputs: in_ready=1, out_valid=0, count=0, out_fu=0, out_* payload=0.
- Reset asserted mid-stream: everything clears on that edge regardless of in_valid or rs_free. The queue accepts again the first cycle after reset deasserts.
- No internal combinational path from in_* to out_*. There is a combinational path from rs_free to pop only, with no loop to in_ready.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 2 cycles with in_valid=1, then release.
  - Response: count=0, out_valid=0, in_ready=1 throughout reset. The first push lands the cycle after release.
- Classification:
  - Stimulus: with rs_free=4'b1111, push opcodes 0000011, 0100011, 1000011, 0110011 back-to-back.
  - Response: out_fu sequence 1, 2, 3, 0, each appearing one cycle after its push edge. count returns to 0.
- Full/wrap:
  - Stimulus: with rs_free=0, push 8 entries (pc 0x100..0x11C).
  - Response: count=8 and in_ready=0; a 9th push is ignored.
  - Stimulus continued: set rs_free=4'b1111 and push 3 more during the drain.
  - Response: pcs pop in order 0x100..0x11C and then the 3 new ones, which confirms pointer wrap.
- Head blocking:
  - Stimulus: queue holds [Load pc=0x200, ALU pc=0x204]; rs_free=4'b0001 for 5 cycles, then 4'b0011.
  - Response: out_pc stays 0x200 with no pop for 5 cycles. Then 0x200 pops, then 0x204.
- Simultaneous push/pop at count=4:
  - Stimulus: in_valid=1 and pop enabled for 3 cycles.
  - Response: count stays 4; data order is preserved.
- Flush:
  - Stimulus: assert flush with count=5 while in_valid=1 and pop enabled.
  - Response: next cycle count=0, out_valid=0; the pushed entry is not retained.
